// File: rtl/btn_step_pkg.sv
// Shared types and default timing for the button step controller.
package btn_step_pkg;

  // Per-channel step generator states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } step_state_e;

  // Default timing, in clock cycles.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_REPEAT_DELAY    = 64;
  localparam int unsigned DEF_REPEAT_PERIOD   = 16;
  localparam int unsigned DEF_CNT_W           = 16;

endpackage

// File: rtl/btn_step_channel.sv
// One button channel: two-flop synchronizer, debounce filter and a
// press/auto-repeat FSM that emits single-cycle step pulses.
module btn_step_channel
  import btn_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic held,
  output logic step
);

  // Timing parameters must each lie in [1, 2^CNT_W - 1].
  localparam logic [CNT_W-1:0] DB_TARGET  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] RD_TARGET  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP_TARGET  = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             sync1, sync2;
  logic             acc;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] db_next;

  step_state_e      state_q, state_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [CNT_W-1:0] rpt_next;
  logic             step_q, step_d;

  // Bring the raw asynchronous button into the clock domain.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Counts cycles that the synchronized level disagrees with the accepted
  // one; flips the accepted level once the disagreement has lasted long enough.
  assign db_next = (db_cnt == CNT_MAX) ? db_cnt : db_cnt + CNT_ONE;

  // Debounce counter and accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt <= '0;
      acc    <= 1'b0;
    end else if (sync2 != acc) begin
      if (db_next == DB_TARGET) begin
        acc    <= ~acc;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_next;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign rpt_next = (rpt_cnt_q == CNT_MAX) ? rpt_cnt_q : rpt_cnt_q + CNT_ONE;

  // Next-state logic: first pulse on press, one after the initial delay,
  // then one every repeat period; release always returns to IDLE silently.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    step_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d   = DELAY;
          rpt_cnt_d = '0;
          step_d    = 1'b1;
        end
      end
      DELAY: begin
        if (!acc) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_next == RD_TARGET) begin
          state_d   = REPEAT;
          rpt_cnt_d = '0;
          step_d    = 1'b1;
        end else begin
          rpt_cnt_d = rpt_next;
        end
      end
      REPEAT: begin
        if (!acc) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_next == RP_TARGET) begin
          rpt_cnt_d = '0;
          step_d    = 1'b1;
        end else begin
          rpt_cnt_d = rpt_next;
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end
    endcase
  end

  // FSM state, repeat timer and registered step pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      step_q    <= step_d;
    end
  end

  assign held = acc;
  assign step = step_q;

endmodule

// File: rtl/button_step_ctrl.sv
// Two-button duty step controller: debounced increase/decrease buttons with
// auto-repeat, conflict masking and a global step enable.
module button_step_ctrl
  import btn_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_inc,
  input  logic btn_dec,
  output logic inc_step,
  output logic dec_step,
  output logic inc_held,
  output logic dec_held
);

  logic inc_pulse, dec_pulse;
  logic conflict;

  btn_step_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_W           (CNT_W)
  ) u_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_inc),
    .held  (inc_held),
    .step  (inc_pulse)
  );

  btn_step_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_W           (CNT_W)
  ) u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_dec),
    .held  (dec_held),
    .step  (dec_pulse)
  );

  // Both buttons accepted at once is ambiguous, so neither step is issued;
  // the channels keep timing underneath and masked pulses are simply lost.
  assign conflict = inc_held & dec_held;
  assign inc_step = ena & inc_pulse & ~conflict;
  assign dec_step = ena & dec_pulse & ~conflict;

endmodule

// File: tb/tb_button_step_ctrl.sv
// Scoreboard bench for button_step_ctrl: stimulus pushes expected outputs
// from a behavioural model, a negedge monitor pops and compares.
module tb_button_step_ctrl;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic btn_inc = 1'b0;
  logic btn_dec = 1'b0;
  logic inc_step, dec_step, inc_held, dec_held;

  always #5 clk = ~clk;

  button_step_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .inc_step (inc_step),
    .dec_step (dec_step),
    .inc_held (inc_held),
    .dec_held (dec_held)
  );

  // Behavioural channel: synchronizer delay, run-length debounce, and a
  // pulse schedule expressed as offsets since the first pulse of a press.
  typedef struct {
    bit s1;
    bit s2;
    bit acc;
    int run;
    bit active;
    int t;
    bit pulse;
  } ch_model_t;

  ch_model_t m_inc = '{default: 0};
  ch_model_t m_dec = '{default: 0};

  function automatic ch_model_t ch_edge(ch_model_t m, bit raw, bit rst);
    ch_model_t n;
    n = m;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    if (m.active && !m.acc) begin
      n.active = 0;
      n.pulse  = 0;
    end else if (m.active) begin
      n.t     = m.t + 1;
      n.pulse = (n.t == RD) || (n.t > RD && ((n.t - RD) % RP) == 0);
    end else if (m.acc) begin
      n.active = 1;
      n.t      = 0;
      n.pulse  = 1;
    end else begin
      n.pulse = 0;
    end
    if (m.s2 != m.acc) begin
      if (m.run + 1 == D) begin
        n.acc = !m.acc;
        n.run = 0;
      end else begin
        n.run = m.run + 1;
      end
    end else begin
      n.run = 0;
    end
    n.s2 = m.s1;
    n.s1 = raw;
    return n;
  endfunction

  logic [3:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Advance one clock: update the model with the inputs seen at the edge,
  // then drive the next inputs and queue the expected outputs.
  task automatic tick(input bit n_rst, input bit n_ena, input bit n_inc, input bit n_dec);
    bit conf;
    @(posedge clk);
    m_inc = ch_edge(m_inc, btn_inc, !rst_n);
    m_dec = ch_edge(m_dec, btn_dec, !rst_n);
    #1;
    rst_n   = n_rst;
    ena     = n_ena;
    btn_inc = n_inc;
    btn_dec = n_dec;
    cyc++;
    conf = m_inc.acc && m_dec.acc;
    exp_q.push_back({n_ena && m_inc.pulse && !conf,
                     n_ena && m_dec.pulse && !conf,
                     m_inc.acc, m_dec.acc});
  endtask

  task automatic hold(input int n, input bit r, input bit e, input bit i, input bit d);
    repeat (n) tick(r, e, i, d);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    logic [3:0] e;
    logic [3:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {inc_step, dec_step, inc_held, dec_held};
      total++;
      if (got !== e)
      begin
        bad++;
        $display("FAIL outputs cyc=%0d {inc_step,dec_step,inc_held,dec_held} got=%b exp=%b",
                 cyc, got, e);
      end
    end
  end

  initial begin
    // Reset, then idle.
    hold(3, 0, 1, 0, 0);
    hold(5, 1, 1, 0, 0);
    // Clean press and release.
    hold(20, 1, 1, 1, 0);
    hold(12, 1, 1, 0, 0);
    // Bounce for 20 cycles, then settle high.
    for (int i = 0; i < 10; i++) hold(2, 1, 1, (i % 2) == 0, 0);
    hold(20, 1, 1, 1, 0);
    hold(12, 1, 1, 0, 0);
    // Long hold on decrease: delay then auto-repeat.
    hold(60, 1, 1, 0, 1);
    hold(12, 1, 1, 0, 0);
    // Conflict: inc held, dec joins, dec released, inc released.
    hold(30, 1, 1, 1, 0);
    hold(30, 1, 1, 1, 1);
    hold(20, 1, 1, 1, 0);
    hold(12, 1, 1, 0, 0);
    // Reset pulse while in auto-repeat, button still held.
    hold(25, 1, 1, 1, 0);
    hold(1, 0, 1, 1, 0);
    hold(20, 1, 1, 1, 0);
    hold(12, 1, 1, 0, 0);
    // Enable low across the delay window.
    hold(8, 1, 1, 0, 1);
    hold(8, 1, 0, 0, 1);
    hold(20, 1, 1, 0, 1);
    hold(12, 1, 1, 0, 0);
    // Random segments.
    for (int s = 0; s < 60; s++) begin
      hold($urandom_range(1, 15), $urandom_range(0, 19) != 0, $urandom_range(0, 5) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
    hold(15, 1, 1, 0, 0);
    // Let the monitor drain the queue, bounded.
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
